// File: rtl/strng_core_mc.sv
// Multi-channel self-timed-ring TRNG core: ring sampling, XOR compression,
// optional decimation, repetition-count health test, word packing and output FIFO.

module strng_str #(
    parameter int             LEN      = 8,
    parameter logic [LEN-1:0] INIT     = 8'b01010000,
    parameter bit             NEG_EDGE = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    output logic [LEN-1:0] o_c
);
    // Token-flow model of the ring: each stage acts as a C-element that copies
    // its forward neighbour whenever that neighbour differs from the reverse one.
    logic [LEN-1:0] r_c;
    logic [LEN-1:0] w_nxt;

    for (genvar k = 0; k < LEN; k++) begin : g_stg
        localparam int KF = (k + LEN - 1) % LEN;
        localparam int KR = (k + 1) % LEN;
        assign w_nxt[k] = (r_c[KF] != r_c[KR]) ? r_c[KF] : r_c[k];
    end

    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge i_clk or negedge i_rstn) begin
            if (!i_rstn) r_c <= INIT;
            else         r_c <= w_nxt;
        end
    end else begin : g_pos
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) r_c <= INIT;
            else         r_c <= w_nxt;
        end
    end

    assign o_c = r_c;
endmodule

module strng_core_mc #(
    parameter int                 STR_LEN    = 8,
    parameter logic [STR_LEN-1:0] STR_INIT   = 8'b01010000,
    parameter int                 NUM_CH     = 2,
    parameter int                 DECIM      = 4,
    parameter int                 OUT_W      = 32,
    parameter int                 FIFO_DEPTH = 4,
    parameter int                 WARMUP_CYC = 64,
    parameter int                 RCT_CUTOFF = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          raw_mode,
    input  logic                          tst_en,
    input  logic                          tst_bit,
    output logic [OUT_W-1:0]              rnd_data,
    output logic                          rnd_valid,
    input  logic                          rnd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          hlt_fail,
    output logic                          busy
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BIT_W  = $clog2(OUT_W);
    localparam int DCNT_W = $clog2(DECIM) + 1;
    localparam int WARM_W = $clog2(WARMUP_CYC) + 1;
    localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
    localparam int NBITS  = NUM_CH * STR_LEN;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_FAIL   = 2'd3;

    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYC - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(OUT_W - 1);
    localparam logic [DCNT_W-1:0] DEC_LAST  = DCNT_W'(DECIM - 1);
    localparam logic [RCT_W-1:0]  RCT_CUT   = RCT_W'(RCT_CUTOFF);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    logic              r_en_q;
    logic              w_ring_rstn;
    logic [NBITS-1:0]  w_sync;
    logic              r_raw;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_en_q <= 1'b0;
        else       r_en_q <= en;
    end

    assign w_ring_rstn = rstn & r_en_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [STR_LEN-1:0] w_a;
        logic [STR_LEN-1:0] w_b;

        strng_str #(.LEN(STR_LEN), .INIT(STR_INIT), .NEG_EDGE(1'b0)) u_ring_a (
            .i_clk(clk), .i_rstn(w_ring_rstn), .o_c(w_a)
        );
        strng_str #(.LEN(STR_LEN), .INIT(STR_INIT), .NEG_EDGE(1'b1)) u_ring_b (
            .i_clk(clk), .i_rstn(w_ring_rstn), .o_c(w_b)
        );

        for (genvar i = 0; i < STR_LEN; i++) begin : g_bit
            logic r_s0, r_s1, r_s2, r_s3, r_sync;

            // Stages 0/1 live in the ring-B edge domain, stage 2 in the stage-0 domain.
            always_ff @(posedge w_b[i] or negedge rstn) begin
                if (!rstn) begin
                    r_s0 <= 1'b0;
                    r_s1 <= 1'b0;
                end else begin
                    r_s0 <= w_a[i];
                    r_s1 <= ~r_s1;
                end
            end

            always_ff @(posedge r_s0 or negedge rstn) begin
                if (!rstn) r_s2 <= 1'b0;
                else       r_s2 <= r_s1;
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_s3   <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_s3   <= r_s2;
                    r_sync <= r_s3;
                end
            end

            assign w_sync[ch*STR_LEN + i] = r_sync;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_raw <= 1'b0;
        else       r_raw <= tst_en ? tst_bit : ^w_sync;
    end

    logic [1:0]        r_state;
    logic [WARM_W-1:0] r_warm;
    logic              r_raw_mode;
    logic [DCNT_W-1:0] r_dcnt;
    logic              r_acc;
    logic [BIT_W-1:0]  r_bitcnt;
    logic [OUT_W-1:0]  r_sr;
    logic              r_prev;
    logic              r_have_prev;
    logic [RCT_W-1:0]  r_rct;
    logic              r_pend;
    logic              r_hlt_fail;

    logic [OUT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;

    logic              w_valid, w_full, w_pop;
    logic              w_dstrobe, w_d, w_word_done, w_rct_fail;
    logic              w_push_new, w_push_pend, w_push;
    logic [DCNT_W-1:0] w_dlast;
    logic [OUT_W-1:0]  w_word, w_push_data;
    logic [RCT_W-1:0]  w_rct_next;

    assign w_valid     = (r_level != '0);
    assign w_full      = (r_level == LVL_FULL);
    assign w_pop       = w_valid & rnd_ready;
    assign w_dlast     = r_raw_mode ? '0 : DEC_LAST;
    assign w_dstrobe   = en && (r_state == S_RUN) && !r_pend && (r_dcnt == w_dlast);
    assign w_d         = r_acc ^ r_raw;
    assign w_word      = {r_sr[OUT_W-2:0], w_d};
    assign w_rct_next  = (r_have_prev && (w_d == r_prev)) ? r_rct + RCT_W'(1) : RCT_W'(1);
    assign w_rct_fail  = w_dstrobe && (w_rct_next == RCT_CUT);
    assign w_word_done = w_dstrobe && (r_bitcnt == BIT_LAST);
    // A fresh word may use a slot freed by a same-cycle pop; a held word waits for a non-full cycle.
    assign w_push_new  = w_word_done && !w_rct_fail && (!w_full || w_pop);
    assign w_push_pend = en && (r_state == S_RUN) && r_pend && !w_full;
    assign w_push      = w_push_new | w_push_pend;
    assign w_push_data = r_pend ? r_sr : w_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_warm      <= '0;
            r_raw_mode  <= 1'b0;
            r_dcnt      <= '0;
            r_acc       <= 1'b0;
            r_bitcnt    <= '0;
            r_sr        <= '0;
            r_prev      <= 1'b0;
            r_have_prev <= 1'b0;
            r_rct       <= '0;
            r_pend      <= 1'b0;
            r_hlt_fail  <= 1'b0;
        end else if (!en) begin
            r_state     <= S_IDLE;
            r_warm      <= '0;
            r_dcnt      <= '0;
            r_acc       <= 1'b0;
            r_bitcnt    <= '0;
            r_sr        <= '0;
            r_prev      <= 1'b0;
            r_have_prev <= 1'b0;
            r_rct       <= '0;
            r_pend      <= 1'b0;
            r_hlt_fail  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_WARMUP;
                    r_warm     <= WARM_LOAD;
                    r_raw_mode <= raw_mode;
                end
                S_WARMUP: begin
                    if (r_warm == '0) r_state <= S_RUN;
                    else              r_warm  <= r_warm - WARM_W'(1);
                end
                S_RUN: begin
                    if (w_rct_fail) begin
                        r_state    <= S_FAIL;
                        r_hlt_fail <= 1'b1;
                    end else if (r_pend) begin
                        if (w_push_pend) r_pend <= 1'b0;
                    end else if (w_dstrobe) begin
                        r_acc       <= 1'b0;
                        r_dcnt      <= '0;
                        r_sr        <= w_word;
                        r_prev      <= w_d;
                        r_have_prev <= 1'b1;
                        r_rct       <= w_rct_next;
                        r_bitcnt    <= (r_bitcnt == BIT_LAST) ? '0 : r_bitcnt + BIT_W'(1);
                        if (w_word_done && !w_push_new) r_pend <= 1'b1;
                    end else begin
                        r_acc  <= r_acc ^ r_raw;
                        r_dcnt <= r_dcnt + DCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Health failure flushes the FIFO in the same cycle, overriding push and pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_rct_fail) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_data;
    end

    assign rnd_valid  = w_valid;
    assign rnd_data   = w_valid ? r_mem[r_rptr] : '0;
    assign fifo_level = r_level;
    assign hlt_fail   = r_hlt_fail;
    assign busy       = (r_state == S_WARMUP) | (r_state == S_RUN);
endmodule

// File: tb/tb_strng_core_mc.sv
// Scoreboard bench for strng_core_mc: injected raw streams, expected words
// modelled from the stream and compared in pop order.

module tb_strng_core_mc;
    localparam int OUT_W      = 32;
    localparam int DECIM      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    localparam int PAT_ALT       = 0;
    localparam int PAT_DEC       = 1;
    localparam int PAT_ONES_LATE = 2;
    localparam int PAT_WORDS     = 3;

    logic             clk = 1'b0;
    logic             rstn, en, raw_mode, tst_en, tst_bit, rnd_ready;
    logic [OUT_W-1:0] rnd_data;
    logic             rnd_valid;
    logic [LVL_W-1:0] fifo_level;
    logic             hlt_fail, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int sidx     = 0;
    int pat_mode = PAT_ALT;
    logic cfg_raw = 1'b1;

    logic [OUT_W-1:0] words [8] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'hC3A5_5A3C,
                                    32'h6B2D_94E1, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
    logic [OUT_W-1:0] exp_q [$];

    strng_core_mc dut (
        .clk(clk), .rstn(rstn), .en(en), .raw_mode(raw_mode),
        .tst_en(tst_en), .tst_bit(tst_bit),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .fifo_level(fifo_level), .hlt_fail(hlt_fail), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Raw bit the bench injects for stream position i (negative = warm-up filler).
    function automatic logic stream_bit(input int i);
        logic [OUT_W-1:0] w;
        if (i < 0) return 1'b0;
        case (pat_mode)
            PAT_ALT:       return (i % 2) == 0;
            PAT_DEC:       return (((i / 4) % 2) == 0) ? ((i % 4) == 0) : ((i % 4) <= 1);
            PAT_ONES_LATE: return (i < OUT_W) ? ((i % 2) == 0) : 1'b1;
            default: begin
                w = words[3'((i / OUT_W) % 8)];
                w = w << (i % OUT_W);
                return w[OUT_W-1];
            end
        endcase
    endfunction

    // Word k: each output bit is the XOR of D consecutive raw bits, first bit ends up as MSB.
    function automatic logic [OUT_W-1:0] expected_word(input int k);
        int dd;
        logic b;
        logic [OUT_W-1:0] w;
        dd = cfg_raw ? 1 : DECIM;
        w  = '0;
        for (int j = 0; j < OUT_W; j++) begin
            b = 1'b0;
            for (int t = 0; t < dd; t++) b ^= stream_bit((k * OUT_W + j) * dd + t);
            w = {w[OUT_W-2:0], b};
        end
        return w;
    endfunction

    task automatic step();
        tst_bit = stream_bit(sidx);
        @(posedge clk);
        #1;
        sidx++;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart(input logic raw, input int pat);
        en = 1'b0;
        rnd_ready = 1'b0;
        step();
        raw_mode = raw;
        cfg_raw  = raw;
        pat_mode = pat;
        sidx     = -64;
        en       = 1'b1;
    endtask

    task automatic pop_word(input string tag);
        logic [OUT_W-1:0] exp_w;
        check_eq({tag, "_vld"}, 64'(rnd_valid), 64'd1);
        check_eq({tag, "_sbq"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check_eq({tag, "_data"}, 64'(rnd_data), 64'(exp_w));
        end
        rnd_ready = 1'b1;
        step();
        rnd_ready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; raw_mode = 1'b1; tst_en = 1'b1; tst_bit = 1'b0; rnd_ready = 1'b0;
        step_n(2);
        check_eq("rst_valid", 64'(rnd_valid), 64'd0);
        check_eq("rst_data",  64'(rnd_data),  64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        check_eq("rst_hlt",   64'(hlt_fail),  64'd0);
        check_eq("rst_busy",  64'(busy),      64'd0);
        rstn = 1'b1;
        step();
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Packing with decimation bypassed
        restart(1'b1, PAT_ALT);
        step();
        check_eq("warm_busy", 64'(busy), 64'd1);
        step_n(95);
        check_eq("pack_early_vld", 64'(rnd_valid), 64'd0);
        step();
        check_eq("pack_vld", 64'(rnd_valid), 64'd1);
        check_eq("pack_lvl", 64'(fifo_level), 64'd1);
        exp_q.push_back(expected_word(0));
        pop_word("pack");

        // Decimation by DECIM
        restart(1'b0, PAT_DEC);
        step_n(192);
        check_eq("dec_early_vld", 64'(rnd_valid), 64'd0);
        step();
        check_eq("dec_vld", 64'(rnd_valid), 64'd1);
        exp_q.push_back(expected_word(0));
        pop_word("dec");

        // Health test: one good word queued, then a constant run
        restart(1'b1, PAT_ONES_LATE);
        step_n(128);
        check_eq("hlt_pre_lvl",  64'(fifo_level), 64'd1);
        check_eq("hlt_pre_flag", 64'(hlt_fail),   64'd0);
        step();
        check_eq("hlt_flag",  64'(hlt_fail),   64'd1);
        check_eq("hlt_vld",   64'(rnd_valid),  64'd0);
        check_eq("hlt_lvl",   64'(fifo_level), 64'd0);
        check_eq("hlt_busy",  64'(busy),       64'd0);
        step_n(3);
        check_eq("hlt_sticky", 64'(hlt_fail), 64'd1);
        en = 1'b0;
        step();
        check_eq("hlt_clear", 64'(hlt_fail), 64'd0);
        en = 1'b1;
        step();
        check_eq("hlt_rewarm", 64'(busy), 64'd1);

        // Back-pressure: fill, stall, single pop, held word lands next cycle
        restart(1'b1, PAT_WORDS);
        step_n(193);
        check_eq("bp_full", 64'(fifo_level), 64'd4);
        for (int k = 0; k < 4; k++) exp_q.push_back(expected_word(k));
        step_n(38);
        check_eq("bp_stall_lvl",  64'(fifo_level), 64'd4);
        check_eq("bp_stall_busy", 64'(busy),       64'd1);
        pop_word("bp_pop0");
        check_eq("bp_after_pop", 64'(fifo_level), 64'd3);
        step();
        check_eq("bp_held_push", 64'(fifo_level), 64'd4);
        exp_q.push_back(expected_word(4));
        for (int k = 1; k <= 4; k++) pop_word("bp_drain");
        check_eq("bp_empty", 64'(fifo_level), 64'd0);

        // Abort mid-word: queued word survives, partial word is dropped
        restart(1'b1, PAT_ALT);
        step_n(97);
        exp_q.push_back(expected_word(0));
        step_n(10);
        en = 1'b0;
        step();
        check_eq("abort_busy", 64'(busy),       64'd0);
        check_eq("abort_lvl",  64'(fifo_level), 64'd1);
        pop_word("abort_keep");
        check_eq("abort_empty", 64'(fifo_level), 64'd0);
        pat_mode = PAT_WORDS;
        sidx     = -64;
        en       = 1'b1;
        step_n(96);
        check_eq("abort_early_vld", 64'(rnd_valid), 64'd0);
        step();
        exp_q.push_back(expected_word(0));
        pop_word("abort_fresh");

        // Reset while running with two words queued
        restart(1'b1, PAT_ALT);
        step_n(129);
        check_eq("rrst_pre_lvl", 64'(fifo_level), 64'd2);
        rstn = 1'b0;
        #1;
        check_eq("rrst_valid", 64'(rnd_valid),  64'd0);
        check_eq("rrst_data",  64'(rnd_data),   64'd0);
        check_eq("rrst_level", 64'(fifo_level), 64'd0);
        check_eq("rrst_hlt",   64'(hlt_fail),   64'd0);
        check_eq("rrst_busy",  64'(busy),       64'd0);
        step();
        check_eq("rrst_hold_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        step();
        check_eq("rrst_rel_busy", 64'(busy), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
